// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon sequencer: FSM state encoding and
// button-vector decode functions (vectors are zero-extended to 16 bits).
package simon_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_APPEND   = 4'd1,
        ST_SHOW_ON  = 4'd2,
        ST_SHOW_OFF = 4'd3,
        ST_WAIT_IN  = 4'd4,
        ST_HELD     = 4'd5,
        ST_CHECK    = 4'd6,
        ST_GOOD     = 4'd7,
        ST_FAIL     = 4'd8,
        ST_CHAMP    = 4'd9
    } seq_state_t;

    localparam int BTN_MAX = 16;

    function automatic logic [4:0] onehot_count(input logic [BTN_MAX-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < BTN_MAX; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Highest set bit wins; callers only use the result when exactly one bit is set.
    function automatic logic [3:0] onehot_to_idx(input logic [BTN_MAX-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < BTN_MAX; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Sequence store: synchronous write, combinational read, no reset
// (contents are always written before they are read back).
module simon_seq_mem #(
    parameter int DEPTH = 32,
    parameter int DW    = 2,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/simon_seq_engine.sv
// Simon game sequencer: stores the colour sequence, plays it back with a
// shrinking on-time, checks player presses and reports good/fail/champion.
module simon_seq_engine #(
    parameter int N_COLORS      = 4,
    parameter int MAX_LEN       = 32,
    parameter int ON_TICKS      = 37500000,
    parameter int OFF_TICKS     = 12500000,
    parameter int ON_MIN        = 12500000,
    parameter int ON_STEP       = 6250000,
    parameter int SPEEDUP_EVERY = 5,
    parameter int TIMEOUT_TICKS = 250000000,
    localparam int CW = ($clog2(N_COLORS) < 1) ? 1 : $clog2(N_COLORS),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [CW-1:0]       rand_in,
    input  logic [N_COLORS-1:0] btn_press,
    input  logic [N_COLORS-1:0] btn_hold,
    input  logic                replay,
    output logic [CW-1:0]       color,
    output logic                show_en,
    output logic                busy,
    output logic [LW-1:0]       round_len,
    output logic                evt_good,
    output logic                evt_fail,
    output logic                evt_champ
);

    import simon_pkg::*;

    localparam int AW      = ($clog2(MAX_LEN) < 1) ? 1 : $clog2(MAX_LEN);
    localparam int SPD_DIV = (SPEEDUP_EVERY == 0) ? 1 : SPEEDUP_EVERY;

    localparam logic [31:0] ON_T   = 32'(ON_TICKS);
    localparam logic [31:0] OFF_T  = 32'(OFF_TICKS);
    localparam logic [31:0] MIN_T  = 32'(ON_MIN);
    localparam logic [31:0] STEP_T = 32'(ON_STEP);
    localparam logic [31:0] TO_T   = 32'(TIMEOUT_TICKS);

    seq_state_t    r_state;
    logic [AW-1:0] r_idx;
    logic [LW-1:0] r_round_len;
    logic [31:0]   r_cur_on;
    logic [31:0]   r_timer;
    logic [CW-1:0] r_pressed;
    logic [CW-1:0] r_color;
    logic          r_show_en;
    logic          r_busy;
    logic          r_evt_good;
    logic          r_evt_fail;
    logic          r_evt_champ;

    logic [AW-1:0] w_raddr;
    logic [CW-1:0] w_rdata;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [CW-1:0] w_show_color;
    logic          w_last;
    logic [15:0]   w_btn16;
    logic [4:0]    w_press_cnt;
    logic [CW-1:0] w_press_idx;
    logic          w_speedup;

    // Reduce on-time by one step, clamped at the floor without wrapping.
    function automatic logic [31:0] next_on(input logic [31:0] cur);
        if (cur > (MIN_T + STEP_T)) begin
            return cur - STEP_T;
        end else begin
            return MIN_T;
        end
    endfunction

    assign w_we        = (r_state == ST_APPEND);
    assign w_waddr     = r_round_len[AW-1:0];
    assign w_last      = ({{(LW-AW){1'b0}}, r_idx} == (r_round_len - {{(LW-1){1'b0}}, 1'b1}));
    assign w_btn16     = 16'(btn_press);
    assign w_press_cnt = onehot_count(w_btn16);
    assign w_press_idx = CW'(onehot_to_idx(w_btn16));
    assign w_speedup   = (SPEEDUP_EVERY != 0) &&
                         ((32'(r_round_len) % 32'(SPD_DIV)) == 32'd0);

    // Bypass the slot being written so the very first step shows without a bubble.
    assign w_show_color = (w_we && (w_waddr == w_raddr)) ? rand_in : w_rdata;

    // Read address points at the step the FSM is about to show or check.
    always_comb begin
        w_raddr = r_idx;
        case (r_state)
            ST_APPEND, ST_WAIT_IN: begin
                w_raddr = {AW{1'b0}};
            end
            ST_SHOW_OFF: begin
                if (w_last) begin
                    w_raddr = r_idx;
                end else begin
                    w_raddr = r_idx + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_raddr = r_idx;
            end
        endcase
    end

    simon_seq_mem #(
        .DEPTH (MAX_LEN),
        .DW    (CW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (rand_in),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    // Game FSM; outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= {AW{1'b0}};
            r_round_len <= {LW{1'b0}};
            r_cur_on    <= ON_T;
            r_timer     <= 32'd0;
            r_pressed   <= {CW{1'b0}};
            r_color     <= {CW{1'b0}};
            r_show_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_evt_good  <= 1'b0;
            r_evt_fail  <= 1'b0;
            r_evt_champ <= 1'b0;
        end else begin
            r_evt_good  <= 1'b0;
            r_evt_fail  <= 1'b0;
            r_evt_champ <= 1'b0;
            r_show_en   <= 1'b0;
            r_color     <= {CW{1'b0}};
            r_busy      <= 1'b1;
            r_timer     <= 32'd0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_APPEND;
                        r_round_len <= {LW{1'b0}};
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_APPEND: begin
                    r_round_len <= r_round_len + {{(LW-1){1'b0}}, 1'b1};
                    r_idx       <= {AW{1'b0}};
                    r_state     <= ST_SHOW_ON;
                    r_show_en   <= 1'b1;
                    r_color     <= w_show_color;
                end
                ST_SHOW_ON: begin
                    if (r_timer == (r_cur_on - 32'd1)) begin
                        r_state <= ST_SHOW_OFF;
                    end else begin
                        r_timer   <= r_timer + 32'd1;
                        r_show_en <= 1'b1;
                        r_color   <= r_color;
                    end
                end
                ST_SHOW_OFF: begin
                    if (r_timer != (OFF_T - 32'd1)) begin
                        r_timer <= r_timer + 32'd1;
                    end else if (w_last) begin
                        r_idx   <= {AW{1'b0}};
                        r_state <= ST_WAIT_IN;
                    end else begin
                        r_idx     <= r_idx + {{(AW-1){1'b0}}, 1'b1};
                        r_state   <= ST_SHOW_ON;
                        r_show_en <= 1'b1;
                        r_color   <= w_show_color;
                    end
                end
                ST_WAIT_IN: begin
                    if (w_press_cnt == 5'd1) begin
                        r_state   <= ST_HELD;
                        r_pressed <= w_press_idx;
                        r_show_en <= 1'b1;
                        r_color   <= w_press_idx;
                    end else if (w_press_cnt != 5'd0) begin
                        r_state    <= ST_FAIL;
                        r_evt_fail <= 1'b1;
                    end else if (replay && (r_idx == {AW{1'b0}})) begin
                        r_state   <= ST_SHOW_ON;
                        r_idx     <= {AW{1'b0}};
                        r_show_en <= 1'b1;
                        r_color   <= w_show_color;
                    end else if (r_timer == (TO_T - 32'd1)) begin
                        r_state    <= ST_FAIL;
                        r_evt_fail <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                ST_HELD: begin
                    if (btn_hold == {N_COLORS{1'b0}}) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_show_en <= 1'b1;
                        r_color   <= r_pressed;
                    end
                end
                ST_CHECK: begin
                    if (r_pressed != w_rdata) begin
                        r_state    <= ST_FAIL;
                        r_evt_fail <= 1'b1;
                    end else if (!w_last) begin
                        r_idx   <= r_idx + {{(AW-1){1'b0}}, 1'b1};
                        r_state <= ST_WAIT_IN;
                    end else if (r_round_len == LW'(MAX_LEN)) begin
                        r_state     <= ST_CHAMP;
                        r_evt_champ <= 1'b1;
                    end else begin
                        r_state    <= ST_GOOD;
                        r_evt_good <= 1'b1;
                    end
                end
                ST_GOOD: begin
                    if (w_speedup) begin
                        r_cur_on <= next_on(r_cur_on);
                    end else begin
                        r_cur_on <= r_cur_on;
                    end
                    r_state <= ST_APPEND;
                end
                ST_FAIL, ST_CHAMP: begin
                    r_round_len <= {LW{1'b0}};
                    r_cur_on    <= ON_T;
                    r_idx       <= {AW{1'b0}};
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign color     = r_color;
    assign show_en   = r_show_en;
    assign busy      = r_busy;
    assign round_len = r_round_len;
    assign evt_good  = r_evt_good;
    assign evt_fail  = r_evt_fail;
    assign evt_champ = r_evt_champ;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Scoreboard bench: stimulus queues expected show pulses and event pulses,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_simon_seq_engine;

    localparam int K_SHOW  = 0;
    localparam int K_GOOD  = 1;
    localparam int K_FAIL  = 2;
    localparam int K_CHAMP = 3;
    localparam int K_NONE  = 4;

    typedef struct {
        int kind;
        int color;
        int at;
        int len;
        int rl;
    } exp_t;

    exp_t q[$];

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] rand_in;
    logic [3:0] btn_press;
    logic [3:0] btn_hold;
    logic       replay;
    logic [1:0] color;
    logic       show_en;
    logic       busy;
    logic [1:0] round_len;
    logic       evt_good;
    logic       evt_fail;
    logic       evt_champ;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    simon_seq_engine #(
        .N_COLORS      (4),
        .MAX_LEN       (3),
        .ON_TICKS      (4),
        .OFF_TICKS     (2),
        .ON_MIN        (2),
        .ON_STEP       (1),
        .SPEEDUP_EVERY (1),
        .TIMEOUT_TICKS (10)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .rand_in   (rand_in),
        .btn_press (btn_press),
        .btn_hold  (btn_hold),
        .replay    (replay),
        .color     (color),
        .show_en   (show_en),
        .busy      (busy),
        .round_len (round_len),
        .evt_good  (evt_good),
        .evt_fail  (evt_fail),
        .evt_champ (evt_champ)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_show(input int col, input int at, input int len);
        exp_t e;
        e.kind = K_SHOW; e.color = col; e.at = at; e.len = len; e.rl = 0;
        q.push_back(e);
    endtask

    task automatic push_ev(input int kind, input int at, input int rl);
        exp_t e;
        e.kind = kind; e.color = 0; e.at = at; e.len = 0; e.rl = rl;
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Press held for 3 cycles; returns in the cycle the hold is released.
    task automatic press(input logic [3:0] mask);
        btn_press = mask;
        btn_hold  = mask;
        step();
        btn_press = 4'b0000;
        repeat (2) step();
        btn_hold = 4'b0000;
    endtask

    task automatic press_exp(input logic [3:0] mask, input int col, input int ev, input int rl);
        int p;
        p = cyc;
        push_show(col, p + 1, 3);
        if (ev != K_NONE) push_ev(ev, p + 5, rl);
        press(mask);
    endtask

    task automatic start_game(input logic [1:0] r);
        rand_in = r;
        start   = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Monitor: collects show pulses and event pulses and checks them against the queue.
    bit   in_pulse = 1'b0;
    int   p_start  = 0;
    int   p_color  = 0;
    int   n_ev     = 0;
    int   ev_kind  = 0;
    exp_t me;

    always @(negedge clk) begin
        if (show_en && !in_pulse) begin
            in_pulse = 1'b1;
            p_start  = cyc;
            p_color  = int'(color);
        end else if (show_en && in_pulse) begin
            check("color_stable", int'(color), p_color);
        end else if (!show_en && in_pulse) begin
            in_pulse = 1'b0;
            if (q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_show: got colour %0d at cycle %0d, required none", p_color, p_start);
            end else begin
                me = q.pop_front();
                check("show_kind", K_SHOW, me.kind);
                check("show_color", p_color, me.color);
                check("show_start", p_start, me.at);
                check("show_len", cyc - p_start, me.len);
            end
        end
        if (!show_en) check("color_zero_when_off", int'(color), 0);
        n_ev = int'(evt_good) + int'(evt_fail) + int'(evt_champ);
        check("evt_exclusive", (n_ev > 1) ? 1 : 0, 0);
        if (n_ev != 0) begin
            ev_kind = evt_good ? K_GOOD : (evt_fail ? K_FAIL : K_CHAMP);
            if (q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", ev_kind, cyc);
            end else begin
                me = q.pop_front();
                check("ev_kind", ev_kind, me.kind);
                check("ev_cycle", cyc, me.at);
                check("ev_round_len", int'(round_len), me.rl);
            end
        end
    end

    int k;

    initial begin
        reset_n = 1'b0; start = 1'b0; rand_in = 2'd0;
        btn_press = 4'b0000; btn_hold = 4'b0000; replay = 1'b0;
        repeat (3) step();
        check("rst_show_en", int'(show_en), 0);
        check("rst_color", int'(color), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_round_len", int'(round_len), 0);
        check("rst_evt_good", int'(evt_good), 0);
        check("rst_evt_fail", int'(evt_fail), 0);
        check("rst_evt_champ", int'(evt_champ), 0);
        reset_n = 1'b1;
        step();

        // Round 1 pass, round 2 wrong second press
        k = cyc;
        push_show(2, k + 2, 4);
        start_game(2'd2);
        check("busy_in_append", int'(busy), 1);
        wait_until(k + 8);
        press_exp(4'b0100, 2, K_GOOD, 1);
        rand_in = 2'd1;
        push_show(2, k + 15, 3);
        push_show(1, k + 20, 3);
        wait_until(k + 16);
        check("round_len_r2", int'(round_len), 2);
        wait_until(k + 25);
        press_exp(4'b0100, 2, K_NONE, 0);
        wait_until(k + 30);
        press_exp(4'b1000, 3, K_FAIL, 2);
        wait_until(k + 36);
        check("fail_round_len", int'(round_len), 0);
        check("fail_busy", int'(busy), 0);

        // Full three-round champion game, on time 4,3,2
        k = cyc;
        push_show(0, k + 2, 4);
        start_game(2'd0);
        wait_until(k + 8);
        press_exp(4'b0001, 0, K_GOOD, 1);
        rand_in = 2'd3;
        push_show(0, k + 15, 3);
        push_show(3, k + 20, 3);
        wait_until(k + 25);
        press_exp(4'b0001, 0, K_NONE, 0);
        wait_until(k + 30);
        press_exp(4'b1000, 3, K_GOOD, 2);
        rand_in = 2'd1;
        push_show(0, k + 37, 2);
        push_show(3, k + 41, 2);
        push_show(1, k + 45, 2);
        wait_until(k + 49);
        press_exp(4'b0001, 0, K_NONE, 0);
        wait_until(k + 54);
        press_exp(4'b1000, 3, K_NONE, 0);
        wait_until(k + 59);
        press_exp(4'b0010, 1, K_CHAMP, 3);
        wait_until(k + 65);
        check("champ_busy", int'(busy), 0);
        check("champ_round_len", int'(round_len), 0);

        // Timeout: fail 10 cycles after entering WAIT_IN
        k = cyc;
        push_show(2, k + 2, 4);
        push_ev(K_FAIL, k + 18, 1);
        start_game(2'd2);
        wait_until(k + 19);
        check("timeout_busy", int'(busy), 0);

        // Two buttons at once
        k = cyc;
        push_show(1, k + 2, 4);
        start_game(2'd1);
        wait_until(k + 8);
        push_ev(K_FAIL, k + 9, 1);
        press(4'b0011);
        wait_until(k + 12);

        // Replay at idx 0 honoured, replay at idx 1 ignored, then reset in SHOW_ON
        k = cyc;
        push_show(3, k + 2, 4);
        start_game(2'd3);
        wait_until(k + 8);
        replay = 1'b1;
        push_show(3, k + 9, 4);
        step();
        replay = 1'b0;
        wait_until(k + 15);
        press_exp(4'b1000, 3, K_GOOD, 1);
        rand_in = 2'd0;
        push_show(3, k + 22, 3);
        push_show(0, k + 27, 3);
        wait_until(k + 32);
        press_exp(4'b1000, 3, K_NONE, 0);
        wait_until(k + 37);
        replay = 1'b1;
        step();
        replay = 1'b0;
        press_exp(4'b0001, 0, K_GOOD, 2);
        rand_in = 2'd2;
        push_show(3, k + 45, 1);
        wait_until(k + 45);
        check("pre_reset_show_en", int'(show_en), 1);
        reset_n = 1'b0;
        step();
        check("mid_rst_show_en", int'(show_en), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_round_len", int'(round_len), 0);
        check("mid_rst_events", int'(evt_good) + int'(evt_fail) + int'(evt_champ), 0);
        reset_n = 1'b1;
        step();

        // start while busy has no effect
        k = cyc;
        push_show(1, k + 2, 4);
        start_game(2'd1);
        wait_until(k + 3);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored_round_len", int'(round_len), 1);
        push_ev(K_FAIL, k + 18, 1);
        wait_until(k + 21);

        check("queue_drained", q.size(), 0);
        check("no_open_pulse", int'(in_pulse), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
